// File: rtl/lm_sm_sequencer.sv
// lm_sm_sequencer: walks an 8-bit register list and moves one memory word per
// selected register, between the register file and data memory (LM/SM).
module lm_sm_sequencer (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        Start,
    input  logic        Mode,
    input  logic [7:0]  Reg_List,
    input  logic [15:0] Base_Addr,
    input  logic [15:0] RF_Data_A,
    input  logic [15:0] Mem_Rd_Data,
    input  logic        Mem_Ack,
    output logic [2:0]  RF_Address_A,
    output logic [2:0]  RF_Address_C,
    output logic [15:0] RF_Data_C,
    output logic        RF_Write,
    output logic [15:0] Mem_Addr,
    output logic [15:0] Mem_Wr_Data,
    output logic        Mem_Req,
    output logic        Mem_We,
    output logic        Busy,
    output logic        Done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SCAN,
        S_MEM,
        S_WB,
        S_DONE
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  mask_q, mask_d;
    logic [2:0]  cur_q, cur_d;
    logic [15:0] addr_q, addr_d;
    logic [15:0] buf_q, buf_d;
    logic        mode_q, mode_d;
    logic [15:0] maddr_q, maddr_d;
    logic [15:0] wdata_q, wdata_d;

    logic [2:0]  low_idx;
    logic [7:0]  mask_clr;

    always_comb begin
        low_idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (mask_q[i]) low_idx = 3'(i);
        end
    end

    assign mask_clr = mask_q & ~(8'b1 << cur_q);

    always_comb begin
        state_d = state_q;
        mask_d  = mask_q;
        cur_d   = cur_q;
        addr_d  = addr_q;
        buf_d   = buf_q;
        mode_d  = mode_q;
        maddr_d = maddr_q;
        wdata_d = wdata_q;
        unique case (state_q)
            S_IDLE: begin
                if (Start) begin
                    mode_d  = Mode;
                    mask_d  = Reg_List;
                    addr_d  = Base_Addr;
                    state_d = (Reg_List == 8'd0) ? S_DONE : S_SCAN;
                end
            end
            S_SCAN: begin
                cur_d   = low_idx;
                maddr_d = addr_q;
                state_d = S_MEM;
            end
            S_MEM: begin
                // keep the last store word so the bus holds after the request
                if (mode_q) wdata_d = RF_Data_A;
                if (Mem_Ack) begin
                    if (!mode_q) begin
                        buf_d   = Mem_Rd_Data;
                        state_d = S_WB;
                    end else begin
                        mask_d  = mask_clr;
                        addr_d  = addr_q + 16'd1;
                        state_d = (mask_clr == 8'd0) ? S_DONE : S_SCAN;
                    end
                end
            end
            S_WB: begin
                mask_d  = mask_clr;
                addr_d  = addr_q + 16'd1;
                state_d = (mask_clr == 8'd0) ? S_DONE : S_SCAN;
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q <= S_IDLE;
            mask_q  <= 8'd0;
            cur_q   <= 3'd0;
            addr_q  <= 16'd0;
            buf_q   <= 16'd0;
            mode_q  <= 1'b0;
            maddr_q <= 16'd0;
            wdata_q <= 16'd0;
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
            cur_q   <= cur_d;
            addr_q  <= addr_d;
            buf_q   <= buf_d;
            mode_q  <= mode_d;
            maddr_q <= maddr_d;
            wdata_q <= wdata_d;
        end
    end

    assign Busy         = (state_q != S_IDLE);
    assign Done         = (state_q == S_DONE);
    assign RF_Write     = (state_q == S_WB);
    assign Mem_Req      = (state_q == S_MEM);
    assign Mem_We       = (state_q == S_MEM) && mode_q;
    assign Mem_Addr     = maddr_q;
    assign Mem_Wr_Data  = ((state_q == S_MEM) && mode_q) ? RF_Data_A : wdata_q;
    assign RF_Address_A = cur_q;
    assign RF_Address_C = cur_q;
    assign RF_Data_C    = buf_q;

endmodule

// File: tb/tb_lm_sm_sequencer.sv
// Directed bench for lm_sm_sequencer with a register-file model and a
// memory responder that inserts a programmable number of wait cycles.
module tb_lm_sm_sequencer;

    logic        Clock;
    logic        Reset;
    logic        Start;
    logic        Mode;
    logic [7:0]  Reg_List;
    logic [15:0] Base_Addr;
    logic [15:0] RF_Data_A;
    logic [15:0] Mem_Rd_Data;
    logic        Mem_Ack;
    logic [2:0]  RF_Address_A;
    logic [2:0]  RF_Address_C;
    logic [15:0] RF_Data_C;
    logic        RF_Write;
    logic [15:0] Mem_Addr;
    logic [15:0] Mem_Wr_Data;
    logic        Mem_Req;
    logic        Mem_We;
    logic        Busy;
    logic        Done;

    lm_sm_sequencer dut (
        .Clock       (Clock),
        .Reset       (Reset),
        .Start       (Start),
        .Mode        (Mode),
        .Reg_List    (Reg_List),
        .Base_Addr   (Base_Addr),
        .RF_Data_A   (RF_Data_A),
        .Mem_Rd_Data (Mem_Rd_Data),
        .Mem_Ack     (Mem_Ack),
        .RF_Address_A(RF_Address_A),
        .RF_Address_C(RF_Address_C),
        .RF_Data_C   (RF_Data_C),
        .RF_Write    (RF_Write),
        .Mem_Addr    (Mem_Addr),
        .Mem_Wr_Data (Mem_Wr_Data),
        .Mem_Req     (Mem_Req),
        .Mem_We      (Mem_We),
        .Busy        (Busy),
        .Done        (Done)
    );

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;
    always @(posedge Clock) cyc <= cyc + 1;

    // register file model, preloaded through its own port while DUT idles
    logic [15:0] rf [8];
    logic        pre_we = 1'b0;
    logic [2:0]  pre_addr = 3'd0;
    logic [15:0] pre_data = 16'd0;
    assign RF_Data_A = rf[RF_Address_A];
    always @(posedge Clock) begin
        if (RF_Write) rf[RF_Address_C] <= RF_Data_C;
        else if (pre_we) rf[pre_addr] <= pre_data;
    end

    // memory responder
    logic [15:0] mem [65536];
    logic [15:0] wl_a[$];
    logic [15:0] wl_d[$];
    logic [15:0] al[$];
    logic        ack_en = 1'b1;
    int          wait_cycles = 0;
    int          wcnt = 0;
    always @(negedge Clock) begin
        if (Reset || !Mem_Req) begin
            wcnt = 0;
            Mem_Ack = 1'b0;
        end else if (ack_en && wcnt >= wait_cycles) begin
            Mem_Ack = 1'b1;
            al.push_back(Mem_Addr);
            if (Mem_We) begin
                wl_a.push_back(Mem_Addr);
                wl_d.push_back(Mem_Wr_Data);
            end else begin
                Mem_Rd_Data = mem[Mem_Addr];
            end
        end else begin
            Mem_Ack = 1'b0;
            wcnt++;
        end
    end

    // event counters and request-stability monitor
    int   done_cnt = 0;
    int   wr_cnt = 0;
    int   req_cnt = 0;
    int   stab_err = 0;
    logic p_req = 1'b0;
    logic p_ack = 1'b0;
    logic p_we = 1'b0;
    logic [15:0] p_addr = 16'd0;
    logic [15:0] p_wd = 16'd0;
    always @(posedge Clock) begin
        p_req  <= Mem_Req;
        p_ack  <= Mem_Ack;
        p_addr <= Mem_Addr;
        p_we   <= Mem_We;
        p_wd   <= Mem_Wr_Data;
    end
    always @(negedge Clock) begin
        if (Done === 1'b1) done_cnt++;
        if (RF_Write === 1'b1) wr_cnt++;
        if (Mem_Req === 1'b1) req_cnt++;
        if (p_req && !p_ack && Mem_Req &&
            (Mem_Addr !== p_addr || Mem_We !== p_we ||
             Mem_Wr_Data !== p_wd))
            stab_err++;
    end

    task automatic pre_load(input logic [2:0] a, input logic [15:0] d);
        @(negedge Clock);
        pre_we = 1'b1;
        pre_addr = a;
        pre_data = d;
        @(posedge Clock);
        #1;
        pre_we = 1'b0;
    endtask

    task automatic start_op(input logic m, input logic [7:0] list,
                            input logic [15:0] base, output int s);
        @(negedge Clock);
        Start = 1'b1;
        Mode = m;
        Reg_List = list;
        Base_Addr = base;
        @(posedge Clock);
        #1;
        Start = 1'b0;
        Reg_List = 8'h5A;
        Base_Addr = 16'hDEAD;
        s = cyc;
    endtask

    task automatic wait_done(input int s, output int lat);
        lat = -1;
        for (int i = 0; i < 200; i++) begin
            @(negedge Clock);
            if (Done === 1'b1) begin
                lat = cyc - s + 1;
                break;
            end
        end
    endtask

    task automatic test_reset;
        int s;
        Reset = 1'b1;
        repeat (2) @(posedge Clock);
        @(negedge Clock);
        vectors++;
        if ({Busy, Done, RF_Write, Mem_Req, Mem_We} !== 5'b0) begin
            miscompares++;
            $display("FAIL reset_ctl got %b want 00000",
                     {Busy, Done, RF_Write, Mem_Req, Mem_We});
        end
        vectors++;
        if ({Mem_Addr, Mem_Wr_Data, RF_Data_C} !== 48'd0) begin
            miscompares++;
            $display("FAIL reset_bus got %h want 0",
                     {Mem_Addr, Mem_Wr_Data, RF_Data_C});
        end
        Reset = 1'b0;
        ack_en = 1'b0;
        start_op(1'b1, 8'h01, 16'h1234, s);
        repeat (3) @(negedge Clock);
        vectors++;
        if (Mem_Req !== 1'b1 || Mem_Addr !== 16'h1234) begin
            miscompares++;
            $display("FAIL reset_pre_req got %b/%h want 1/1234",
                     Mem_Req, Mem_Addr);
        end
        Reset = 1'b1;
        repeat (2) @(posedge Clock);
        @(negedge Clock);
        vectors++;
        if ({Busy, Done, RF_Write, Mem_Req, Mem_We} !== 5'b0) begin
            miscompares++;
            $display("FAIL reset_mid_ctl got %b want 00000",
                     {Busy, Done, RF_Write, Mem_Req, Mem_We});
        end
        vectors++;
        if ({Mem_Addr, Mem_Wr_Data, RF_Data_C,
             RF_Address_A, RF_Address_C} !== 54'd0) begin
            miscompares++;
            $display("FAIL reset_mid_bus got %h want 0",
                     {Mem_Addr, Mem_Wr_Data, RF_Data_C,
                      RF_Address_A, RF_Address_C});
        end
        Reset = 1'b0;
        ack_en = 1'b1;
    endtask

    task automatic test_sm;
        int s, lat, wb, db, rb, n;
        pre_load(3'd0, 16'h1111);
        pre_load(3'd2, 16'h2222);
        pre_load(3'd7, 16'h7777);
        wait_cycles = 0;
        wb = wl_a.size();
        db = done_cnt;
        rb = wr_cnt;
        start_op(1'b1, 8'b1000_0101, 16'h0100, s);
        wait_done(s, lat);
        vectors++;
        if (lat !== 7) begin
            miscompares++;
            $display("FAIL sm_latency got %0d want 7", lat);
        end
        repeat (3) @(negedge Clock);
        n = wl_a.size() - wb;
        vectors++;
        if (n !== 3) begin
            miscompares++;
            $display("FAIL sm_nwrites got %0d want 3", n);
        end else begin
            vectors++;
            if (wl_a[wb] !== 16'h0100 || wl_d[wb] !== 16'h1111 ||
                wl_a[wb+1] !== 16'h0101 || wl_d[wb+1] !== 16'h2222 ||
                wl_a[wb+2] !== 16'h0102 || wl_d[wb+2] !== 16'h7777) begin
                miscompares++;
                $display("FAIL sm_data got %h@%h %h@%h %h@%h",
                         wl_d[wb], wl_a[wb], wl_d[wb+1], wl_a[wb+1],
                         wl_d[wb+2], wl_a[wb+2]);
            end
        end
        vectors++;
        if (wr_cnt - rb !== 0) begin
            miscompares++;
            $display("FAIL sm_rfwrite got %0d want 0", wr_cnt - rb);
        end
        vectors++;
        if (done_cnt - db !== 1) begin
            miscompares++;
            $display("FAIL sm_done_cnt got %0d want 1", done_cnt - db);
        end
    endtask

    task automatic test_lm_wrap;
        int s, lat, ab, db, rb, sb;
        mem[16'hFFFF] = 16'hAAAA;
        mem[16'h0000] = 16'h5555;
        wait_cycles = 2;
        ab = al.size();
        db = done_cnt;
        rb = wr_cnt;
        sb = stab_err;
        start_op(1'b0, 8'h81, 16'hFFFF, s);
        wait_done(s, lat);
        vectors++;
        if (lat !== 11) begin
            miscompares++;
            $display("FAIL lm_latency got %0d want 11", lat);
        end
        vectors++;
        if (Busy !== 1'b1) begin
            miscompares++;
            $display("FAIL lm_busy_done got %b want 1", Busy);
        end
        @(negedge Clock);
        vectors++;
        if (Busy !== 1'b0) begin
            miscompares++;
            $display("FAIL lm_busy_after got %b want 0", Busy);
        end
        vectors++;
        if (rf[0] !== 16'hAAAA || rf[7] !== 16'h5555) begin
            miscompares++;
            $display("FAIL lm_rf got %h/%h want aaaa/5555", rf[0], rf[7]);
        end
        vectors++;
        if (al.size() - ab !== 2 || al[ab] !== 16'hFFFF ||
            al[ab+1] !== 16'h0000) begin
            miscompares++;
            $display("FAIL lm_wrap got %0d accesses", al.size() - ab);
        end
        vectors++;
        if (wr_cnt - rb !== 2) begin
            miscompares++;
            $display("FAIL lm_rfwrite got %0d want 2", wr_cnt - rb);
        end
        vectors++;
        if (stab_err - sb !== 0) begin
            miscompares++;
            $display("FAIL lm_stable got %0d changes want 0", stab_err - sb);
        end
        vectors++;
        if (done_cnt - db !== 1) begin
            miscompares++;
            $display("FAIL lm_done_cnt got %0d want 1", done_cnt - db);
        end
    endtask

    task automatic test_empty;
        int s, lat, qb, rb;
        qb = req_cnt;
        rb = wr_cnt;
        start_op(1'b0, 8'h00, 16'h4000, s);
        wait_done(s, lat);
        vectors++;
        if (lat !== 1) begin
            miscompares++;
            $display("FAIL empty_latency got %0d want 1", lat);
        end
        repeat (2) @(negedge Clock);
        vectors++;
        if (req_cnt - qb !== 0 || wr_cnt - rb !== 0) begin
            miscompares++;
            $display("FAIL empty_activity got req %0d wr %0d want 0/0",
                     req_cnt - qb, wr_cnt - rb);
        end
    endtask

    task automatic test_reset_mid_lm;
        int s, lat, rb;
        logic seen;
        pre_load(3'd3, 16'h3333);
        mem[16'h0200] = 16'hBEEF;
        ack_en = 1'b0;
        rb = wr_cnt;
        seen = 1'b0;
        start_op(1'b0, 8'h08, 16'h0200, s);
        for (int i = 0; i < 10; i++) begin
            @(negedge Clock);
            if (Mem_Req === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        vectors++;
        if (seen !== 1'b1) begin
            miscompares++;
            $display("FAIL rmid_req got %b want 1", seen);
        end
        Reset = 1'b1;
        @(negedge Clock);
        vectors++;
        if (Mem_Req !== 1'b0 || RF_Write !== 1'b0 || Busy !== 1'b0) begin
            miscompares++;
            $display("FAIL rmid_outputs got %b%b%b want 000",
                     Mem_Req, RF_Write, Busy);
        end
        Reset = 1'b0;
        ack_en = 1'b1;
        wait_cycles = 0;
        @(negedge Clock);
        vectors++;
        if (wr_cnt - rb !== 0 || rf[3] !== 16'h3333) begin
            miscompares++;
            $display("FAIL rmid_rf got %0d writes R3=%h want 0/3333",
                     wr_cnt - rb, rf[3]);
        end
        start_op(1'b0, 8'h08, 16'h0200, s);
        wait_done(s, lat);
        vectors++;
        if (lat !== 4 || rf[3] !== 16'hBEEF) begin
            miscompares++;
            $display("FAIL rmid_rerun got lat %0d R3=%h want 4/beef",
                     lat, rf[3]);
        end
    endtask

    task automatic test_start_busy;
        int s, lat, wb, db;
        pre_load(3'd1, 16'h0101);
        wait_cycles = 1;
        wb = wl_a.size();
        db = done_cnt;
        start_op(1'b1, 8'h06, 16'h0300, s);
        repeat (2) @(negedge Clock);
        Start = 1'b1;
        Mode = 1'b0;
        Reg_List = 8'hFF;
        Base_Addr = 16'h0000;
        repeat (3) @(negedge Clock);
        Start = 1'b0;
        wait_done(s, lat);
        vectors++;
        if (lat !== 7) begin
            miscompares++;
            $display("FAIL busy_latency got %0d want 7", lat);
        end
        repeat (4) @(negedge Clock);
        vectors++;
        if (wl_a.size() - wb !== 2) begin
            miscompares++;
            $display("FAIL busy_nwrites got %0d want 2", wl_a.size() - wb);
        end else begin
            vectors++;
            if (wl_a[wb] !== 16'h0300 || wl_d[wb] !== 16'h0101 ||
                wl_a[wb+1] !== 16'h0301 || wl_d[wb+1] !== 16'h2222) begin
                miscompares++;
                $display("FAIL busy_data got %h@%h %h@%h want 0101@0300 2222@0301",
                         wl_d[wb], wl_a[wb], wl_d[wb+1], wl_a[wb+1]);
            end
        end
        vectors++;
        if (done_cnt - db !== 1 || Busy !== 1'b0) begin
            miscompares++;
            $display("FAIL busy_done got %0d dones busy=%b want 1/0",
                     done_cnt - db, Busy);
        end
    endtask

    initial begin
        Reset = 1'b1;
        Start = 1'b0;
        Mode = 1'b0;
        Reg_List = 8'h00;
        Base_Addr = 16'h0000;
        test_reset();
        test_sm();
        test_lm_wrap();
        test_empty();
        test_reset_mid_lm();
        test_start_busy();
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
